// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcodes and fetch-stage states.
// Used by the fetch stage and the decoder.
package cpu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_J   = 2'b11;

   localparam int OPC_HI = 7;
   localparam int OPC_LO = 6;
   localparam int RS_HI  = 5;
   localparam int RS_LO  = 4;
   localparam int RT_HI  = 3;
   localparam int RT_LO  = 2;
   localparam int IMM_HI = 1;
   localparam int IMM_LO = 0;
   localparam int OFF_HI = 5;
   localparam int OFF_LO = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   function automatic logic [7:0] sext_off(input logic [5:0] off);
      return {{2{off[5]}}, off};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, decode valid/ready output and redirect input.
// master = fetch stage side, slave = memory/decode side.
interface fetch_unit_if;
   logic [7:0] fetch_addr;
   logic [7:0] fetch_instr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_instr;
   logic [7:0] out_pc;
   logic       redirect_valid;
   logic [7:0] redirect_pc;

   modport master (
      output fetch_addr, out_valid, out_instr, out_pc,
      input  fetch_instr, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  fetch_addr, out_valid, out_instr, out_pc,
      output fetch_instr, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC logic: pc+1, jump target pc+1+sext(off), self-jump detect.
// Zero latency; no flow control.
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [7:0] pc_i,
   input  logic [7:0] instr_i,
   output logic [7:0] pc_inc_o,
   output logic [7:0] jump_tgt_o,
   output logic       is_jump_o,
   output logic       self_jump_o
);

   logic [5:0] off;

   assign off         = instr_i[OFF_HI:OFF_LO];
   assign pc_inc_o    = pc_i + 8'd1;
   assign jump_tgt_o  = pc_inc_o + sext_off(off);
   assign is_jump_o   = (instr_i[OPC_HI:OPC_LO] == OP_J);
   // An offset of -1 lands back on the jump itself.
   assign self_jump_o = is_jump_o && (off == 6'h3F);

endmodule

// File: rtl/fetch_unit.sv
// PC + instruction fetch with jump folding; one word per cycle into a valid/ready output register.
// Output register stalls the PC when full and not drained; folded jumps advance regardless.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [7:0] RESET_PC  = 8'd0,
   parameter int         MEM_DEPTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   fetch_unit_if.master  bus,
   output logic          halted,
   output logic          fault
);

   fetch_state_e state_q, state_d;
   logic [7:0]   pc_q, pc_d;
   logic         out_valid_q, out_valid_d;
   logic [7:0]   out_instr_q, out_instr_d;
   logic [7:0]   out_pc_q, out_pc_d;
   logic         fault_q, fault_d;

   logic [7:0]   pc_inc;
   logic [7:0]   jump_tgt;
   logic         is_jump;
   logic         self_jump;
   logic         out_of_range;

   next_pc_calc u_next_pc (
      .pc_i        (pc_q),
      .instr_i     (bus.fetch_instr),
      .pc_inc_o    (pc_inc),
      .jump_tgt_o  (jump_tgt),
      .is_jump_o   (is_jump),
      .self_jump_o (self_jump)
   );

   assign out_of_range = (int'({24'd0, pc_q}) >= MEM_DEPTH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= 8'h00;
         out_pc_q    <= 8'h00;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         fault_q     <= fault_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      fault_d     = fault_q;

      // Drain happens in every state; a capture below overrides it.
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (bus.redirect_valid) begin
               pc_d        = bus.redirect_pc;
               out_valid_d = 1'b0;
            end else if (out_of_range) begin
               state_d = HALT;
               fault_d = 1'b1;
            end else if (is_jump) begin
               if (self_jump) begin
                  state_d = HALT;
               end else begin
                  pc_d = jump_tgt;
               end
            end else if (!out_valid_q || bus.out_ready) begin
               out_valid_d = 1'b1;
               out_instr_d = bus.fetch_instr;
               out_pc_d    = pc_q;
               pc_d        = pc_inc;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.fetch_addr = pc_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_instr  = out_instr_q;
   assign bus.out_pc     = out_pc_q;
   assign halted         = (state_q == HALT);
   assign fault          = fault_q;

endmodule
